// File: rtl/i2c_eeprom_access_sched_pkg.sv
// i2c_eeprom_access_sched_pkg: byte-master opcodes, sequencer states and sizing helper
package i2c_eeprom_access_sched_pkg;
  localparam logic [1:0] OP_WR = 2'd0;
  localparam logic [1:0] OP_RD = 2'd1;
  localparam logic [1:0] OP_STOP = 2'd2;
  typedef enum logic [3:0] {
    S_IDLE, S_DEVW, S_MAH, S_MAL, S_WDAT, S_POLL, S_PSTOP, S_DEVR, S_RDAT, S_ABORT, S_DONE, S_ERR
  } state_t;
  function automatic int poll_w(input int pmax);
    return pmax > 255 ? $clog2(pmax + 1) : 8;
  endfunction
endpackage

// File: rtl/i2c_eeprom_access_sched_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, priority moves past the port granted on upd
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);
  logic prio;
  // contention resolved by priority pointer, single requester always wins
  always_comb gnt = (&req) ? (prio ? 2'b10 : 2'b01) : req;
  // after a grant the other port gets priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio <= 1'b0;
    else if (upd) prio <= gnt[0];
endmodule

// File: rtl/i2c_eeprom_access_sched.sv
// i2c_eeprom_access_sched: shares one I2C byte master between two requesters as 24Cxx read/write sequences
module i2c_eeprom_access_sched
  import i2c_eeprom_access_sched_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int ADDR_BYTES = 1,
  parameter int POLL_MAX = 255
) (
  input  logic        ICE_CLK,
  input  logic        RST_N,
  input  logic [1:0]  rq_valid,
  output logic [1:0]  rq_ready,
  input  logic [1:0]  rq_we,
  input  logic [31:0] rq_addr,
  input  logic [15:0] rq_wdata,
  output logic [1:0]  rs_valid,
  output logic        rs_err,
  output logic [7:0]  rs_rdata,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic [1:0]  m_cmd_op,
  output logic        m_cmd_start,
  output logic        m_cmd_stop,
  output logic        m_cmd_nack,
  output logic [7:0]  m_cmd_wdata,
  input  logic        m_rsp_valid,
  input  logic        m_rsp_nack,
  input  logic [7:0]  m_rsp_rdata,
  output logic        busy
);
  localparam int PW = poll_w(POLL_MAX);
  localparam logic [PW-1:0] PMAX = PW'(POLL_MAX);
  if (ADDR_BYTES != 1 && ADDR_BYTES != 2) begin : g_bad_addr_bytes
    $error("ADDR_BYTES must be 1 or 2");
  end
  state_t state, nxt;
  logic port, we, pend, poll_ok, rsp, cmd_st;
  logic [15:0] addr;
  logic [7:0] wdata, rdata;
  logic [PW-1:0] poll_cnt;
  logic [1:0] arb_req, gnt;
  assign arb_req = (state == S_IDLE) ? rq_valid : 2'b00;
  rr_arbiter2 u_arb (.clk(ICE_CLK), .rst_n(RST_N), .req(arb_req), .upd(|gnt), .gnt(gnt));
  assign rq_ready = gnt;
  assign busy = (state != S_IDLE) | (|gnt);
  assign cmd_st = !(state inside {S_IDLE, S_DONE, S_ERR});
  assign rsp = pend & m_rsp_valid;
  assign m_cmd_valid = cmd_st & ~pend;
  assign m_cmd_op = (state inside {S_PSTOP, S_ABORT}) ? OP_STOP : (state == S_RDAT) ? OP_RD : OP_WR;
  assign m_cmd_start = state inside {S_DEVW, S_POLL, S_DEVR};
  assign m_cmd_stop = state inside {S_WDAT, S_RDAT};
  assign m_cmd_nack = state == S_RDAT;
  assign m_cmd_wdata = (state inside {S_DEVW, S_POLL}) ? {DEV_ADDR, 1'b0} :
                       (state == S_DEVR) ? {DEV_ADDR, 1'b1} :
                       (state == S_MAH) ? addr[15:8] :
                       (state == S_MAL) ? addr[7:0] :
                       (state == S_WDAT) ? wdata : 8'h00;
  assign rs_valid = (state inside {S_DONE, S_ERR}) ? {port, ~port} : 2'b00;
  assign rs_err = state == S_ERR;
  assign rs_rdata = (state == S_DONE && !we) ? rdata : 8'h00;
  // sequencing: each command state advances only on the response to its own command
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (|gnt) nxt = S_DEVW;
      S_DEVW:  if (rsp) nxt = m_rsp_nack ? S_ABORT : (ADDR_BYTES == 2 ? S_MAH : S_MAL);
      S_MAH:   if (rsp) nxt = m_rsp_nack ? S_ABORT : S_MAL;
      S_MAL:   if (rsp) nxt = m_rsp_nack ? S_ABORT : (we ? S_WDAT : S_DEVR);
      S_WDAT:  if (rsp) nxt = m_rsp_nack ? S_ERR : S_POLL;
      S_POLL:  if (rsp) nxt = S_PSTOP;
      S_PSTOP: if (rsp) nxt = poll_ok ? S_DONE : (poll_cnt == PMAX ? S_ERR : S_POLL);
      S_DEVR:  if (rsp) nxt = m_rsp_nack ? S_ABORT : S_RDAT;
      S_RDAT:  if (rsp) nxt = S_DONE;
      S_ABORT: if (rsp) nxt = S_ERR;
      default: nxt = S_IDLE;
    endcase
  end
  // state register; reset abandons any sequence and drops m_cmd_valid at once
  always_ff @(posedge ICE_CLK or negedge RST_N)
    if (!RST_N) state <= S_IDLE;
    else state <= nxt;
  // request capture, outstanding-command flag, read data and ACK-poll bookkeeping
  always_ff @(posedge ICE_CLK or negedge RST_N)
    if (!RST_N) begin
      {port, we, pend, poll_ok} <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      poll_cnt <= '0;
    end else begin
      pend <= (m_cmd_valid & m_cmd_ready) | (pend & ~m_rsp_valid);
      if (|gnt) begin
        port <= gnt[1];
        we <= gnt[1] ? rq_we[1] : rq_we[0];
        addr <= gnt[1] ? rq_addr[31:16] : rq_addr[15:0];
        wdata <= gnt[1] ? rq_wdata[15:8] : rq_wdata[7:0];
        rdata <= '0;
      end
      if (rsp && state == S_RDAT) rdata <= m_rsp_rdata;
      if (rsp && state == S_POLL) poll_ok <= ~m_rsp_nack;
      if (rsp && state == S_WDAT) poll_cnt <= '0;
      if (rsp && state == S_PSTOP && !poll_ok) poll_cnt <= poll_cnt + 1'b1;
    end
endmodule

// File: tb/tb_i2c_eeprom_access_sched.sv
// tb_i2c_eeprom_access_sched: scoreboard bench with an EEPROM-like byte-master model
module tb_i2c_eeprom_access_sched;
  import i2c_eeprom_access_sched_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic [1:0] rq_valid = '0, rq_we = '0;
  logic [31:0] rq_addr = '0;
  logic [15:0] rq_wdata = '0;
  logic m_cmd_ready = 1'b0, m_rsp_valid = 1'b0, m_rsp_nack = 1'b0;
  logic [7:0] m_rsp_rdata = '0;
  logic [1:0] rdy_o [2], rsv_o [2], op_o [2];
  logic err_o [2], cv_o [2], st_o [2], sp_o [2], nk_o [2], bz_o [2];
  logic [7:0] rd_o [2], wd_o [2];
  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    localparam bit S = (i == 1);
    i2c_eeprom_access_sched #(.ADDR_BYTES(i + 1), .POLL_MAX(i ? 2 : 255)) u_dut (
      .ICE_CLK(clk), .RST_N(rst_n),
      .rq_valid(sel == S ? rq_valid : 2'b00), .rq_ready(rdy_o[i]), .rq_we(rq_we),
      .rq_addr(rq_addr), .rq_wdata(rq_wdata),
      .rs_valid(rsv_o[i]), .rs_err(err_o[i]), .rs_rdata(rd_o[i]),
      .m_cmd_valid(cv_o[i]), .m_cmd_ready(sel == S && m_cmd_ready), .m_cmd_op(op_o[i]),
      .m_cmd_start(st_o[i]), .m_cmd_stop(sp_o[i]), .m_cmd_nack(nk_o[i]), .m_cmd_wdata(wd_o[i]),
      .m_rsp_valid(sel == S && m_rsp_valid), .m_rsp_nack(m_rsp_nack), .m_rsp_rdata(m_rsp_rdata),
      .busy(bz_o[i]));
  end

  logic [1:0] c_rdy, c_rsv, c_op;
  logic c_err, c_cv, c_st, c_sp, c_nk, c_bz;
  logic [7:0] c_rd, c_wd;
  logic [12:0] c_cmd;
  logic [27:0] outs;
  assign c_rdy = rdy_o[sel];
  assign c_rsv = rsv_o[sel];
  assign c_op = op_o[sel];
  assign c_err = err_o[sel];
  assign c_cv = cv_o[sel];
  assign c_st = st_o[sel];
  assign c_sp = sp_o[sel];
  assign c_nk = nk_o[sel];
  assign c_bz = bz_o[sel];
  assign c_rd = rd_o[sel];
  assign c_wd = wd_o[sel];
  assign c_cmd = {c_op, c_st, c_sp, c_nk, c_wd};
  assign outs = {c_rdy, c_rsv, c_err, c_rd, c_cv, c_cmd, c_bz};

  localparam logic [12:0] STOP_C = {OP_STOP, 3'b000, 8'h00};
  localparam logic [12:0] RD_C = {OP_RD, 3'b011, 8'h00};
  function automatic logic [12:0] wr(input logic [7:0] d, input logic s, input logic p);
    return {OP_WR, s, p, 1'b0, d};
  endfunction

  logic [12:0] cmd_q[$];
  logic [10:0] rs_q[$];
  int checks = 0, errors = 0;
  int n_acc = 0, stall_after = 1 << 30, busy_left = 0, poll_nacks = 0;
  bit dev_present = 1'b1;
  logic [7:0] rd_byte = 8'h00;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic expire(input string n);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", n);
  endtask

  // byte master + EEPROM model: checks each accepted command, answers one cycle later
  initial begin
    bit pend = 1'b0, holding = 1'b0, nack_nxt = 1'b0;
    logic [7:0] rdata_nxt = 8'h00;
    logic [12:0] hold = '0;
    forever begin
      @(negedge clk);
      m_rsp_valid = 1'b0;
      m_rsp_nack = 1'b0;
      m_rsp_rdata = 8'h00;
      if (!rst_n) begin
        pend = 1'b0;
        holding = 1'b0;
        m_cmd_ready = 1'b0;
        continue;
      end
      if (pend) begin
        m_rsp_valid = 1'b1;
        m_rsp_nack = nack_nxt;
        m_rsp_rdata = rdata_nxt;
        pend = 1'b0;
      end
      if (holding) chk("cmd_hold", {c_cv, c_cmd}, {1'b1, hold});
      holding = 1'b0;
      m_cmd_ready = (n_acc < stall_after) && ($urandom_range(0, 2) != 0);
      if (c_cv && !m_cmd_ready) begin
        holding = 1'b1;
        hold = c_cmd;
      end
      if (c_cv && m_cmd_ready) begin
        n_acc++;
        if (cmd_q.size() == 0) expire("cmd_unexpected");
        else chk("cmd", c_cmd, cmd_q.pop_front());
        nack_nxt = 1'b0;
        rdata_nxt = 8'h00;
        if (c_op == OP_WR) begin
          if (!dev_present) nack_nxt = 1'b1;
          else if (c_st && busy_left > 0) begin
            nack_nxt = 1'b1;
            busy_left--;
          end
          if (c_sp && !nack_nxt) busy_left = poll_nacks;
        end else if (c_op == OP_RD) rdata_nxt = rd_byte;
        pend = 1'b1;
      end
    end
  end

  // response monitor: pops the scoreboard on every completion pulse
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (prev) chk("busy_fall", c_bz, |c_rdy);
      prev = |c_rsv;
      if (|c_rdy) chk("one_grant", $countones(c_rdy), 1);
      if (prev) begin
        if (rs_q.size() == 0) expire("rs_unexpected");
        else chk("rs", {c_bz, c_rsv, c_err, c_rd}, {1'b1, rs_q.pop_front()});
      end
    end
  end

  task automatic req(input int p, input bit w, input logic [15:0] a, input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    rq_valid[p] = 1'b1;
    rq_we[p] = w;
    rq_addr[p*16 +: 16] = a;
    rq_wdata[p*8 +: 8] = d;
    #1;
    while (!c_rdy[p] && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k == 400) expire("grant_wait");
    @(posedge clk);
    #1 rq_valid[p] = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((rs_q.size() != 0 || c_bz || rq_valid != 0) && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k == 3000) expire("done_wait");
    chk("cmds_left", cmd_q.size(), 0);
    cmd_q.delete();
  endtask

  task automatic push_read(input logic [7:0] a);
    cmd_q.push_back(wr(8'hA0, 1'b1, 1'b0));
    cmd_q.push_back(wr(a, 1'b0, 1'b0));
    cmd_q.push_back(wr(8'hA1, 1'b1, 1'b0));
    cmd_q.push_back(RD_C);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 chk("reset_outs", outs, 0);
    rst_n = 1'b1;
    // read, port 0
    rd_byte = 8'hA5;
    push_read(8'h3C);
    rs_q.push_back({2'b01, 1'b0, 8'hA5});
    fork
      req(0, 1'b0, 16'h003C, 8'h00);
      begin
        repeat (3) @(negedge clk);
        rq_valid[1] = 1'b1;
        repeat (2) @(negedge clk);
        rq_valid[1] = 1'b0;
      end
    join
    wait_done();
    // write, port 1, three busy polls then ack
    poll_nacks = 3;
    cmd_q.push_back(wr(8'hA0, 1'b1, 1'b0));
    cmd_q.push_back(wr(8'h10, 1'b0, 1'b0));
    cmd_q.push_back(wr(8'h5A, 1'b0, 1'b1));
    for (int k = 0; k < 4; k++) begin
      cmd_q.push_back(wr(8'hA0, 1'b1, 1'b0));
      cmd_q.push_back(STOP_C);
    end
    rs_q.push_back({2'b10, 1'b0, 8'h00});
    req(1, 1'b1, 16'h0010, 8'h5A);
    wait_done();
    chk("poll_consumed", busy_left, 0);
    // contention twice: grant order 0,1,0,1
    rd_byte = 8'h77;
    for (int k = 1; k <= 4; k++) begin
      push_read(8'(k));
      rs_q.push_back({(k % 2 == 1) ? 2'b01 : 2'b10, 1'b0, 8'h77});
    end
    fork
      req(0, 1'b0, 16'h0001, 8'h00);
      req(1, 1'b0, 16'h0002, 8'h00);
    join
    fork
      req(0, 1'b0, 16'h0003, 8'h00);
      req(1, 1'b0, 16'h0004, 8'h00);
    join
    wait_done();
    // no device answers
    dev_present = 1'b0;
    cmd_q.push_back(wr(8'hA0, 1'b1, 1'b0));
    cmd_q.push_back(STOP_C);
    rs_q.push_back({2'b01, 1'b1, 8'h00});
    req(0, 1'b0, 16'h0055, 8'h00);
    wait_done();
    dev_present = 1'b1;
    // two-byte address, poll limit 2, device never ready
    @(negedge clk);
    sel = 1'b1;
    poll_nacks = 1000;
    cmd_q.push_back(wr(8'hA0, 1'b1, 1'b0));
    cmd_q.push_back(wr(8'h12, 1'b0, 1'b0));
    cmd_q.push_back(wr(8'h34, 1'b0, 1'b0));
    cmd_q.push_back(wr(8'h99, 1'b0, 1'b1));
    for (int k = 0; k < 3; k++) begin
      cmd_q.push_back(wr(8'hA0, 1'b1, 1'b0));
      cmd_q.push_back(STOP_C);
    end
    rs_q.push_back({2'b01, 1'b1, 8'h00});
    req(0, 1'b1, 16'h1234, 8'h99);
    wait_done();
    chk("poll_attempts", busy_left, 997);
    busy_left = 0;
    poll_nacks = 0;
    // reset while the low address byte is stalled
    begin
      int k = 0;
      stall_after = n_acc + 2;
      cmd_q.push_back(wr(8'hA0, 1'b1, 1'b0));
      cmd_q.push_back(wr(8'h12, 1'b0, 1'b0));
      req(0, 1'b0, 16'h1234, 8'h00);
      while (!(c_cv && c_cmd == wr(8'h34, 1'b0, 1'b0)) && k < 100) begin
        @(negedge clk);
        #1;
        k++;
      end
      if (k == 100) expire("mal_wait");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("reset_async", outs, 0);
      chk("mah_sent", cmd_q.size(), 0);
      repeat (2) @(negedge clk);
      stall_after = 1 << 30;
      rst_n = 1'b1;
    end
    // sequencer works again after reset
    rd_byte = 8'h3C;
    cmd_q.push_back(wr(8'hA0, 1'b1, 1'b0));
    cmd_q.push_back(wr(8'h00, 1'b0, 1'b0));
    cmd_q.push_back(wr(8'hFF, 1'b0, 1'b0));
    cmd_q.push_back(wr(8'hA1, 1'b1, 1'b0));
    cmd_q.push_back(RD_C);
    rs_q.push_back({2'b10, 1'b0, 8'h3C});
    req(1, 1'b0, 16'h00FF, 8'h00);
    wait_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
